// File: rtl/pixel_pkg.sv
// Shared definitions for the LED frame scheduler.
//   state_t     : scheduler FSM state encoding
//   COLOR_BITS  : width of one packed pixel word {R,B,G}
//   CHAN_BITS   : width of one color channel
//   *_OFS       : bit offset of each channel inside the pixel word
//   scale_chan  : (c * (brightness+1)) >> 8 for one channel
package pixel_pkg;

    localparam int COLOR_BITS = 24;
    localparam int CHAN_BITS  = 8;
    localparam int R_OFS      = 16;
    localparam int B_OFS      = 8;
    localparam int G_OFS      = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_SEND      = 3'd3,
        ST_LATCH     = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // A 9-bit multiplier of brightness+1 makes 255 an exact passthrough
    // and 0 a full blank.
    function automatic logic [CHAN_BITS-1:0] scale_chan(
        input logic [CHAN_BITS-1:0] c,
        input logic [7:0]           b
    );
        logic [8:0]  mult;
        logic [15:0] prod;
        mult = {1'b0, b} + 9'd1;
        prod = {8'd0, c} * {7'd0, mult};
        return CHAN_BITS'(prod >> 8);
    endfunction

endpackage

// File: rtl/pixel_scale.sv
// Combinational 3-channel brightness scaler.
//   i_color [23:0] : packed pixel {R,B,G}
//   i_scale [7:0]  : global brightness
//   o_color [23:0] : scaled pixel, same packing
module pixel_scale
    import pixel_pkg::*;
(
    input  logic [COLOR_BITS-1:0] i_color,
    input  logic [7:0]            i_scale,
    output logic [COLOR_BITS-1:0] o_color
);

    assign o_color[R_OFS +: CHAN_BITS] = scale_chan(i_color[R_OFS +: CHAN_BITS], i_scale);
    assign o_color[B_OFS +: CHAN_BITS] = scale_chan(i_color[B_OFS +: CHAN_BITS], i_scale);
    assign o_color[G_OFS +: CHAN_BITS] = scale_chan(i_color[G_OFS +: CHAN_BITS], i_scale);

endmodule

// File: rtl/pixel_frame_scheduler.sv
// Reads one frame of pixels from a synchronous frame buffer, scales them by
// a global brightness, pushes them to pixel_driver over valid/ready and
// finishes every frame with a single latch/reset command.
//
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   start, continuous     : frame start pulse, auto-restart enable
//   abort                 : stop after the current pixel, then latch
//   brightness [7:0]      : global scale, sampled at each frame start
//   mem_rd_en, mem_addr   : frame-buffer read port (data 1 cycle later)
//   mem_rdata [23:0]      : frame-buffer read data {R,B,G}
//   drv_color/reset/valid : command to pixel_driver, drv_ready back
//   busy                  : frame in progress
//   frame_done            : one-cycle pulse after latch accepted
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for start
// FETCH     | one-cycle read strobe for pixel idx
// WAIT_DATA | RAM data arriving, capture scaled color
// SEND      | color command valid, waiting for ready
// LATCH     | latch/reset command valid, waiting for ready
// DONE      | frame_done pulse, restart or return to IDLE
module pixel_frame_scheduler
    import pixel_pkg::*;
#(
    parameter int NUM_PIXELS = 64,
    parameter int ADDR_BITS  = 6
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  abort,
    input  logic [7:0]            brightness,
    output logic                  mem_rd_en,
    output logic [ADDR_BITS-1:0]  mem_addr,
    input  logic [COLOR_BITS-1:0] mem_rdata,
    output logic [COLOR_BITS-1:0] drv_color,
    output logic                  drv_reset,
    output logic                  drv_valid,
    input  logic                  drv_ready,
    output logic                  busy,
    output logic                  frame_done
);

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_PIXELS - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_BITS-1:0]    r_idx;
    logic [7:0]              r_brightness;
    logic [COLOR_BITS-1:0]   r_color;
    logic                    r_reset;
    logic                    r_abort_pending;
    logic [COLOR_BITS-1:0]   w_scaled;
    logic                    w_accept;
    logic                    w_abort_eff;
    logic                    w_end_frame;
    logic                    w_restart;

    pixel_scale u_scale (
        .i_color (mem_rdata),
        .i_scale (r_brightness),
        .o_color (w_scaled)
    );

    // drv_valid depends on state only, so ready never feeds back into valid.
    assign drv_valid   = (r_state == ST_SEND) || (r_state == ST_LATCH);
    assign w_accept    = drv_valid && drv_ready;
    // An abort arriving in the accept cycle still counts for this pixel.
    assign w_abort_eff = r_abort_pending || abort;
    assign w_end_frame = (r_idx == LAST_IDX) || w_abort_eff;
    assign w_restart   = continuous && !w_abort_eff;
    assign drv_color   = r_color;
    assign drv_reset   = r_reset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        busy       = (r_state != ST_IDLE);
        frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rd_en = 1'b1;
                mem_addr  = r_idx;
                w_next    = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                w_next = ST_SEND;
            end
            ST_SEND: begin
                if (w_accept) w_next = w_end_frame ? ST_LATCH : ST_FETCH;
            end
            ST_LATCH: begin
                if (w_accept) w_next = ST_DONE;
            end
            ST_DONE: begin
                frame_done = 1'b1;
                w_next     = w_restart ? ST_FETCH : ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx           <= '0;
            r_brightness    <= '0;
            r_color         <= '0;
            r_reset         <= 1'b0;
            r_abort_pending <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_abort_pending <= 1'b0;
            end else if (abort) begin
                r_abort_pending <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_brightness <= brightness;
                        r_idx        <= '0;
                    end
                end
                ST_WAIT_DATA: begin
                    r_color <= w_scaled;
                    r_reset <= 1'b0;
                end
                ST_SEND: begin
                    if (w_accept) begin
                        if (w_end_frame) begin
                            r_color <= '0;
                            r_reset <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_reset <= 1'b0;
                    if (w_restart) begin
                        r_idx        <= '0;
                        r_brightness <= brightness;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
